// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow process: registered block,
// debounced sticky deadlock flag, cause snapshot and saturating event count.
module hls_deadlock_monitor_param #(
   parameter int                N_AXIS    = 3,
   parameter int                N_IDLE    = 5,
   parameter int                N_BLOCK   = 2,
   parameter logic [N_AXIS-1:0] AXIS_MASK = {N_AXIS{1'b1}},
   parameter int                THRESH_W  = 8,
   parameter int                CNT_W     = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_AXIS-1:0]         axis_block_sigs,
   input  logic [N_IDLE-1:0]         inst_idle_sigs,
   input  logic [N_BLOCK-1:0]        inst_block_sigs,
   input  logic [THRESH_W-1:0]       threshold,
   input  logic                      clear,
   output logic                      block,
   output logic                      deadlock,
   output logic [N_AXIS+N_BLOCK-1:0] cause,
   output logic [CNT_W-1:0]          deadlock_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WATCH,
      S_DEADLOCK
   } state_e;

   localparam int SRC_W = N_AXIS + N_BLOCK;

   state_e              state_q, state_d;
   logic [THRESH_W-1:0] run_q, run_d;
   logic                block_q, block_d;
   logic                deadlock_q, deadlock_d;
   logic [SRC_W-1:0]    cause_q, cause_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [SRC_W-1:0]    src;
   logic                cur;
   logic [THRESH_W-1:0] t_eff;
   logic [THRESH_W:0]   run_nx;
   logic                enter;

   assign src    = {inst_block_sigs, axis_block_sigs & AXIS_MASK};
   // a fully idle design is never blocked
   assign cur    = (|src) & ~(&inst_idle_sigs);
   assign t_eff  = (threshold == '0) ? THRESH_W'(1) : threshold;
   assign run_nx = {1'b0, run_q} + (THRESH_W + 1)'(1);

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      block_d    = cur;
      deadlock_d = deadlock_q;
      cause_d    = cause_q;
      count_d    = count_q;
      enter      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cur) begin
               if (t_eff == THRESH_W'(1)) begin
                  enter = 1'b1;
               end else begin
                  state_d = S_WATCH;
                  run_d   = THRESH_W'(1);
               end
            end
         end
         S_WATCH: begin
            if (!cur) begin
               state_d = S_IDLE;
               run_d   = '0;
            end else if (run_nx >= {1'b0, t_eff}) begin
               enter = 1'b1;
            end else if (run_q != '1) begin
               run_d = run_q + THRESH_W'(1);
            end
         end
         S_DEADLOCK: begin
            state_d = S_DEADLOCK;
         end
         default: begin
            state_d = S_IDLE;
            run_d   = '0;
         end
      endcase

      if (enter) begin
         state_d    = S_DEADLOCK;
         deadlock_d = 1'b1;
         cause_d    = src;
         if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
         end
      end

      // clear wins over a same-cycle entry and never touches the count
      if (clear) begin
         state_d    = S_IDLE;
         run_d      = '0;
         deadlock_d = 1'b0;
         cause_d    = '0;
         count_d    = count_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         run_q      <= '0;
         block_q    <= 1'b0;
         deadlock_q <= 1'b0;
         cause_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         block_q    <= block_d;
         deadlock_q <= deadlock_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
      end
   end

   assign block          = block_q;
   assign deadlock       = deadlock_q;
   assign cause          = cause_q;
   assign deadlock_count = count_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Bench for hls_deadlock_monitor_param: directed scenarios then random
// traffic, all checked every cycle against a run-length reference model.
module tb_hls_deadlock_monitor_param;

   localparam logic [2:0] MASK = 3'b011;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] ab;
   logic [4:0] ii;
   logic [1:0] ib;
   logic [3:0] th;
   logic       clr;
   logic       block;
   logic       deadlock;
   logic [4:0] cause;
   logic [1:0] deadlock_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         m_run;
   bit         m_blk;
   bit         m_dl;
   logic [4:0] m_cause;
   int         m_cnt;

   always #5 clock = ~clock;

   hls_deadlock_monitor_param #(
      .N_AXIS(3), .N_IDLE(5), .N_BLOCK(2), .AXIS_MASK(MASK),
      .THRESH_W(4), .CNT_W(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .axis_block_sigs(ab),
      .inst_idle_sigs(ii),
      .inst_block_sigs(ib),
      .threshold(th),
      .clear(clr),
      .block(block),
      .deadlock(deadlock),
      .cause(cause),
      .deadlock_count(deadlock_count)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: advance the model with the sampled inputs, then compare
   task automatic cyc();
      logic [4:0] src;
      bit         c;
      int         te;
      @(posedge clock);
      src = {ib, ab & MASK};
      c   = (src != 0) && (ii != 5'b11111);
      te  = (th == 0) ? 1 : int'(th);
      if (reset) begin
         m_run = 0; m_blk = 0; m_dl = 0; m_cause = 0; m_cnt = 0;
      end else begin
         m_blk = c;
         if (clr) begin
            m_run = 0; m_dl = 0; m_cause = 0;
         end else if (!m_dl) begin
            if (c) begin
               m_run++;
               if (m_run >= te) begin
                  m_dl    = 1;
                  m_cause = src;
                  if (m_cnt < 3) m_cnt++;
               end
            end else begin
               m_run = 0;
            end
         end
      end
      #1;
      check("block", 32'(block), 32'(m_blk));
      check("deadlock", 32'(deadlock), 32'(m_dl));
      check("cause", 32'(cause), 32'(m_cause));
      check("count", 32'(deadlock_count), 32'(m_cnt));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_clear();
      clr = 1; cyc(); clr = 0;
   endtask

   initial begin
      reset = 1; ab = 0; ii = 0; ib = 0; th = 4; clr = 0;
      m_run = 0; m_blk = 0; m_dl = 0; m_cause = 0; m_cnt = 0;
      run(2);
      reset = 0;
      check("rst_dl", 32'(deadlock), 0);
      check("rst_cnt", 32'(deadlock_count), 0);
      run(20);
      check("idle_blk", 32'(block), 0);

      // debounce: 3-cycle stall is too short, 4 cycles trips
      ab = 3'b010; run(3);
      check("dbn_blk", 32'(block), 1);
      ab = 0; run(2);
      check("dbn_short", 32'(deadlock), 0);
      ab = 3'b010; run(3);
      check("dbn_pre", 32'(deadlock), 0);
      run(1);
      check("dbn_dl", 32'(deadlock), 1);
      check("dbn_cause", 32'(cause), 32'h02);
      check("dbn_cnt", 32'(deadlock_count), 1);

      // sticky, then clear
      ab = 0; run(5);
      check("sticky", 32'(deadlock), 1);
      pulse_clear();
      check("clr_dl", 32'(deadlock), 0);
      check("clr_cause", 32'(cause), 0);
      check("clr_cnt", 32'(deadlock_count), 1);

      // masked channel and idle gating
      ab = 3'b100; run(50);
      check("mask_blk", 32'(block), 0);
      check("mask_dl", 32'(deadlock), 0);
      ab = 0; ib = 2'b01; ii = 5'b11111; run(10);
      check("idle_gate", 32'(block), 0);
      ib = 0; ii = 0; run(1);

      // clear on the exact threshold edge
      ab = 3'b001; run(3);
      clr = 1; cyc(); clr = 0;
      check("edge_dl", 32'(deadlock), 0);
      check("edge_cnt", 32'(deadlock_count), 1);
      run(3);
      check("edge_rerun", 32'(deadlock), 0);
      run(1);
      check("edge_dl2", 32'(deadlock), 1);
      ab = 0; pulse_clear();

      // threshold 0 behaves as 1
      th = 0; ab = 3'b010; run(1);
      check("t0_blk", 32'(block), 1);
      check("t0_dl", 32'(deadlock), 1);
      ab = 0; pulse_clear();

      // count saturation at 3
      th = 1;
      for (int k = 0; k < 4; k++) begin
         ab = 3'b001; run(1); ab = 0; pulse_clear();
      end
      check("sat_cnt", 32'(deadlock_count), 3);

      // all-ones threshold
      th = 4'hf; ab = 3'b001; run(14);
      check("tmax_pre", 32'(deadlock), 0);
      run(1);
      check("tmax_dl", 32'(deadlock), 1);
      ab = 0; pulse_clear();

      // lowering threshold mid-run
      th = 8; ib = 2'b10; run(5);
      check("lower_pre", 32'(deadlock), 0);
      th = 3; run(1);
      check("lower_dl", 32'(deadlock), 1);
      check("lower_cause", 32'(cause), 32'h10);
      ib = 0; pulse_clear();

      // reset while deadlocked with the stall still present
      th = 2; ab = 3'b011; run(2);
      check("rmid_pre", 32'(deadlock), 1);
      reset = 1; run(1); reset = 0;
      check("rmid_dl", 32'(deadlock), 0);
      check("rmid_cnt", 32'(deadlock_count), 0);
      run(1);
      check("rmid_re0", 32'(deadlock), 0);
      run(1);
      check("rmid_re1", 32'(deadlock), 1);
      ab = 0; pulse_clear();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         ab  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) ab = 0;
         ib  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         ii  = ($urandom_range(0, 5) == 0) ? 5'b11111 : 5'($urandom);
         if ($urandom_range(0, 15) == 0) th = 4'($urandom_range(0, 6));
         clr   = ($urandom_range(0, 19) == 0);
         reset = ($urandom_range(0, 199) == 0);
         cyc();
      end
      reset = 0; clr = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hls_deadlock_monitor_param.md
# hls_deadlock_monitor_param

Parametrised deadlock monitor for HLS dataflow regions in the ADC-to-OPFB pipeline. One instance sits beside each dataflow process (e.g. `adc2iq`). It watches that process's AXI-stream stall signals and its sub-instance block and idle signals. It reports an instantaneous registered `block`, as the per-process monitors already do. It adds a debounced, sticky `deadlock` flag that asserts only after a programmable run of consecutive blocked cycles, a snapshot of which sources caused the deadlock, and a saturating count of deadlock events for debug readback.

## Interface
- `N_AXIS`, default 3: number of AXI-stream block inputs.
- `N_IDLE`, default 5: number of sub-instance idle inputs.
- `N_BLOCK`, default 2: number of sub-instance block inputs.
- `AXIS_MASK`, default `{N_AXIS{1'b1}}`: per-channel enable for `axis_block_sigs`; a 0 bit excludes that channel.
- `THRESH_W`, default 8: width of `threshold` and of the run counter.
- `CNT_W`, default 16: width of `deadlock_count`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `axis_block_sigs` in N_AXIS: per-channel stream stall (full/empty while the process waits).
- `inst_idle_sigs` in N_IDLE: sub-instance idle flags.
- `inst_block_sigs` in N_BLOCK: sub-instance block flags.
- `threshold` in THRESH_W: consecutive blocked cycles required to declare deadlock; 0 is treated as 1.
- `clear` in 1: single-cycle pulse that drops the sticky state.
- `block` out 1: registered instantaneous blocked indication.
- `deadlock` out 1: sticky deadlock flag.
- `cause` out N_AXIS+N_BLOCK: snapshot `{inst_block_sigs, axis_block_sigs & AXIS_MASK}` taken at deadlock entry.
- `deadlock_count` out CNT_W: number of deadlock entries, saturating.

## Operation
- Combinational term `cur = (|(axis_block_sigs & AXIS_MASK) | |inst_block_sigs) & ~(&inst_idle_sigs)`.
  - A design that is fully idle is never treated as blocked.
- `block` register: loads `cur` every cycle.
- State machine (`IDLE`, `WATCH`, `DEADLOCK`) with run counter `run_cnt` (THRESH_W bits, saturating at all-ones). `T_eff = max(threshold, 1)`, compared live each cycle.
- `IDLE`:
  - `cur=1` and `T_eff=1`: go to `DEADLOCK`.
  - `cur=1` otherwise: go to `WATCH`, `run_cnt<=1`.
  - `cur=0`: stay in `IDLE`.
- `WATCH`:
  - `cur=0`: go to `IDLE`, `run_cnt<=0`.
  - `cur=1` and `run_cnt+1 >= T_eff`: go to `DEADLOCK`.
  - `cur=1` otherwise: increment `run_cnt`.
- `DEADLOCK`: held regardless of `cur` until `clear` or `reset`.
  - On `clear`: go to `IDLE`, `run_cnt<=0`.
- Deadlock entry (same edge as the state change into `DEADLOCK`):
  - `deadlock<=1`.
  - `cause<=` current masked source vector.
  - `deadlock_count` increments unless it is all-ones.
- `clear` in any state forces `IDLE`, `run_cnt<=0`, `deadlock<=0`, `cause<=0`.
  - `clear` has priority over a simultaneous entry condition.
  - The cycle in which `clear` is asserted is not counted toward a new run.
  - `clear` does not affect `block` or `deadlock_count`.
- `deadlock_count` is cleared only by `reset`.

## Timing
- Reset values: `block=0`, `deadlock=0`, `cause=0`, `deadlock_count=0`, state `IDLE`, `run_cnt=0`.
- `reset` has priority over `clear` and all inputs.
- `block` latency: 1 cycle from `cur` (high in cycle n → `block` high in n+1).
- `deadlock` latency: if `cur` is high for cycles c..c+T_eff-1, `deadlock` is high from cycle c+T_eff.
  - With `T_eff=1`, `deadlock` rises together with `block`.
- A single `cur=0` cycle inside a run restarts the count from 0.
- Lowering `threshold` mid-run below `run_cnt+1` triggers `DEADLOCK` on the next `cur=1` edge.
- With `threshold` all-ones, `run_cnt` saturates and entry occurs at the edge where the run reaches 2^THRESH_W-1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset and idle: hold `reset` for 2 cycles with all inputs at 0, then release → all outputs 0 and `block` stays 0 for 20 cycles.
- Debounce: `threshold=4`, `axis_block_sigs=3'b010` for 3 cycles, then 0 → `block` high for 3 cycles, `deadlock` stays 0.
  - Repeat the stall for 4 cycles → `deadlock=1` from the 5th cycle, `cause=5'b00010`, `deadlock_count=1`.
- Masking and idle gating, with `AXIS_MASK=3'b011`:
  - `axis_block_sigs=3'b100` for 50 cycles → `block=0`, `deadlock=0`.
  - `inst_block_sigs=2'b01` with `inst_idle_sigs=5'b11111` → `block=0`.
- Stickiness and clear: after deadlock, release all stalls → `deadlock` stays 1.
  - Pulse `clear` → `deadlock=0` and `cause=0` next cycle; `deadlock_count` unchanged.
  - Pulse `clear` on the exact threshold edge → `deadlock` stays 0 and `deadlock_count` does not increment.
- Threshold 0 and saturation:
  - `threshold=0` with a 1-cycle stall → `deadlock` and `block` rise in the same cycle.
  - With `CNT_W=2`, perform 5 deadlock/clear cycles → `deadlock_count` saturates at 3.
- Reset mid-deadlock: assert `reset` while `deadlock=1` and the stall is still active → all outputs 0 next cycle.
  - After `reset` is released, the run restarts and `deadlock` re-asserts `T_eff` cycles later.
